// File: rtl/tick_counter_pkg.sv
// Purpose: shared encodings for the tick counter (limit modes, count direction).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tick_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_counter_if.sv
// Purpose: control/status bundle between the button layer and the tick counter.
// Latency: n/a (wiring only).
// Backpressure: none; the master freezes the counter with enable=0.
interface tick_counter_if #(
    parameter int WIDTH     = 16,
    parameter int LED_COUNT = 4
);
    logic                 enable;
    logic                 load;
    logic [WIDTH-1:0]     load_value;
    logic [WIDTH-1:0]     step;
    logic                 dir;
    logic [1:0]           mode;
    logic [WIDTH-1:0]     count;
    logic                 tick;
    logic                 limit_hit;
    logic [LED_COUNT-1:0] leds;

    modport master (
        output enable, load, load_value, step, dir, mode,
        input  count, tick, limit_hit, leds
    );

    modport slave (
        input  enable, load, load_value, step, dir, mode,
        output count, tick, limit_hit, leds
    );
endinterface

// File: rtl/tick_counter_prescaler.sv
// Purpose: clock-enable generator; flags the last cycle of every PRESCALE enabled cycles.
// Latency: terminal is combinational from the phase register (high in cycle PRESCALE-1).
// Backpressure: enable=0 holds the phase; clear restarts the phase at 0.
module tick_counter_prescaler #(
    parameter int PRESCALE = 12000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic enable,
    input  logic clear,
    output logic terminal
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign terminal = enable && (phase == LAST);

    // Phase counter: restart on clear, wrap at LAST, hold while disabled.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end
endmodule

// File: rtl/tick_counter.sv
// Purpose: prescaled up/down step counter with wrap, saturate and bounce limits; LEDs show the top bits.
// Latency: count/tick/limit_hit update together one edge after the terminal prescaler cycle.
// Backpressure: none; enable=0 freezes prescaler and count, load overrides everything.
module tick_counter
    import tick_counter_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          PRESCALE  = 12000000,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
    parameter int          LED_COUNT = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    tick_counter_if.slave cnt_if
);
    // One extra bit so count+step and count+modulus never overflow.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MAX_COUNT);
    localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + (WIDTH + 1)'(1);

    logic             terminal;
    logic [WIDTH-1:0] count_q;
    logic             tick_q;
    logic             limit_q;
    logic             bounce_dir_q;

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_count;
    logic             next_limit;
    logic             next_bounce_dir;

    tick_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock    (Clock),
        .Reset    (Reset),
        .enable   (cnt_if.enable),
        .clear    (cnt_if.load),
        .terminal (terminal)
    );

    // Step/limit datapath: effective step is clamped to MAX_COUNT, then the mode picks the limit rule.
    always_comb begin
        cnt_ext         = {1'b0, count_q};
        step_ext        = ({1'b0, cnt_if.step} > MAX_EXT) ? MAX_EXT : {1'b0, cnt_if.step};
        sum_ext         = cnt_ext + step_ext;
        load_clamped    = ({1'b0, cnt_if.load_value} > MAX_EXT) ? MAX_EXT[WIDTH-1:0]
                                                                 : cnt_if.load_value;
        next_count      = count_q;
        next_limit      = 1'b0;
        next_bounce_dir = bounce_dir_q;

        case (mode_e'(cnt_if.mode))
            MODE_SAT: begin
                if (cnt_if.dir == DIR_UP) begin
                    if (sum_ext >= MAX_EXT) begin
                        next_count = MAX_EXT[WIDTH-1:0];
                        next_limit = (sum_ext > MAX_EXT);
                    end else begin
                        next_count = WIDTH'(sum_ext);
                    end
                end else begin
                    if (step_ext >= cnt_ext) begin
                        next_count = '0;
                        next_limit = (step_ext > cnt_ext);
                    end else begin
                        next_count = WIDTH'(cnt_ext - step_ext);
                    end
                end
            end
            MODE_BOUNCE: begin
                if (bounce_dir_q == DIR_UP) begin
                    if ((step_ext != '0) && (sum_ext >= MAX_EXT)) begin
                        next_count      = MAX_EXT[WIDTH-1:0];
                        next_limit      = 1'b1;
                        next_bounce_dir = DIR_DOWN;
                    end else begin
                        next_count = WIDTH'(sum_ext);
                    end
                end else begin
                    if ((step_ext != '0) && (cnt_ext <= step_ext)) begin
                        next_count      = '0;
                        next_limit      = 1'b1;
                        next_bounce_dir = DIR_UP;
                    end else begin
                        next_count = WIDTH'(cnt_ext - step_ext);
                    end
                end
            end
            default: begin
                // Wrap; the reserved encoding lands here as well.
                if (cnt_if.dir == DIR_UP) begin
                    if (sum_ext > MAX_EXT) begin
                        next_count = WIDTH'(sum_ext - MOD_EXT);
                        next_limit = 1'b1;
                    end else begin
                        next_count = WIDTH'(sum_ext);
                    end
                end else begin
                    if (step_ext > cnt_ext) begin
                        next_count = WIDTH'(cnt_ext + MOD_EXT - step_ext);
                        next_limit = 1'b1;
                    end else begin
                        next_count = WIDTH'(cnt_ext - step_ext);
                    end
                end
            end
        endcase
    end

    // Count register: load beats a same-cycle terminal, otherwise step on terminal, else hold.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q      <= '0;
            tick_q       <= 1'b0;
            limit_q      <= 1'b0;
            bounce_dir_q <= DIR_UP;
        end else if (cnt_if.load) begin
            count_q <= load_clamped;
            tick_q  <= 1'b0;
            limit_q <= 1'b0;
        end else if (terminal) begin
            count_q      <= next_count;
            tick_q       <= 1'b1;
            limit_q      <= next_limit;
            bounce_dir_q <= next_bounce_dir;
        end else begin
            tick_q  <= 1'b0;
            limit_q <= 1'b0;
        end
    end

    assign cnt_if.count     = count_q;
    assign cnt_if.tick      = tick_q;
    assign cnt_if.limit_hit = limit_q;
    assign cnt_if.leds      = count_q[WIDTH-1 -: LED_COUNT];
endmodule

// File: tb/tb_tick_counter.sv
// Purpose: directed self-checking bench for tick_counter (8-bit PRESCALE=3 and 16-bit PRESCALE=1 instances).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_tick_counter;

    logic Clock;
    logic Reset;
    int   total_cnt;
    int   pass_cnt;
    int   fail_cnt;

    tick_counter_if #(.WIDTH(8),  .LED_COUNT(4)) ifa ();
    tick_counter_if #(.WIDTH(16), .LED_COUNT(4)) ifb ();

    tick_counter #(
        .WIDTH(8), .PRESCALE(3), .MAX_COUNT(9), .LED_COUNT(4)
    ) dut_a (
        .Clock  (Clock),
        .Reset  (Reset),
        .cnt_if (ifa)
    );

    tick_counter #(
        .WIDTH(16), .PRESCALE(1), .MAX_COUNT(65535), .LED_COUNT(4)
    ) dut_b (
        .Clock  (Clock),
        .Reset  (Reset),
        .cnt_if (ifb)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_b[7];
        int exp_l[7];
        exp_b = '{9, 7, 5, 3, 1, 0, 2};
        exp_l = '{1, 0, 0, 0, 0, 1, 0};
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;

        Reset = 1'b0;
        ifa.enable = 1'b0; ifa.load = 1'b0; ifa.load_value = '0;
        ifa.step = '0; ifa.dir = 1'b0; ifa.mode = 2'b00;
        ifb.enable = 1'b0; ifb.load = 1'b0; ifb.load_value = '0;
        ifb.step = '0; ifb.dir = 1'b0; ifb.mode = 2'b00;
        #1 Reset = 1'b1;

        // Reset state
        cyc(2);
        chk("rst_count", 32'(ifa.count), 32'd0);
        chk("rst_tick",  32'(ifa.tick), 32'd0);
        chk("rst_limit", 32'(ifa.limit_hit), 32'd0);
        chk("rst_leds",  32'(ifa.leds), 32'd0);

        // Wrap up, step 4: 0 -> 4 -> 8 -> 2
        Reset = 1'b0;
        ifa.enable = 1'b1; ifa.step = 8'd4; ifa.dir = 1'b0; ifa.mode = 2'b00;
        cyc(2);
        chk("wrap_pre_tick", 32'(ifa.tick), 32'd0);
        chk("wrap_pre_count", 32'(ifa.count), 32'd0);
        cyc(1);
        chk("wrap_t1_tick", 32'(ifa.tick), 32'd1);
        chk("wrap_t1_count", 32'(ifa.count), 32'd4);
        chk("wrap_t1_limit", 32'(ifa.limit_hit), 32'd0);
        cyc(1);
        chk("wrap_gap_tick", 32'(ifa.tick), 32'd0);
        cyc(2);
        chk("wrap_t2_count", 32'(ifa.count), 32'd8);
        chk("wrap_t2_limit", 32'(ifa.limit_hit), 32'd0);
        cyc(3);
        chk("wrap_t3_count", 32'(ifa.count), 32'd2);
        chk("wrap_t3_limit", 32'(ifa.limit_hit), 32'd1);
        chk("wrap_t3_tick", 32'(ifa.tick), 32'd1);

        // Saturate down from 5, step 3: 2, 0, 0
        ifa.load = 1'b1; ifa.load_value = 8'd5; ifa.step = 8'd3; ifa.dir = 1'b1; ifa.mode = 2'b01;
        cyc(1);
        chk("sat_load_count", 32'(ifa.count), 32'd5);
        chk("sat_load_tick", 32'(ifa.tick), 32'd0);
        ifa.load = 1'b0;
        cyc(3);
        chk("sat_t1_count", 32'(ifa.count), 32'd2);
        chk("sat_t1_limit", 32'(ifa.limit_hit), 32'd0);
        cyc(3);
        chk("sat_t2_count", 32'(ifa.count), 32'd0);
        chk("sat_t2_limit", 32'(ifa.limit_hit), 32'd1);
        cyc(3);
        chk("sat_t3_count", 32'(ifa.count), 32'd0);
        chk("sat_t3_limit", 32'(ifa.limit_hit), 32'd1);
        chk("sat_t3_tick", 32'(ifa.tick), 32'd1);
        ifa.load = 1'b1; ifa.load_value = 8'd200;
        cyc(1);
        chk("load_clamp", 32'(ifa.count), 32'd9);
        ifa.load = 1'b0;

        // Bounce from 7, step 2, dir input ignored
        ifa.load = 1'b1; ifa.load_value = 8'd7; ifa.step = 8'd2; ifa.mode = 2'b10;
        cyc(1);
        ifa.load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ifa.dir = 1'($urandom_range(1, 0));
            cyc(3);
            chk($sformatf("bounce_count%0d", i), 32'(ifa.count), 32'(exp_b[i]));
            chk($sformatf("bounce_limit%0d", i), 32'(ifa.limit_hit), 32'(exp_l[i]));
        end

        // Load on the terminal prescaler cycle wins
        cyc(2);
        ifa.load = 1'b1; ifa.load_value = 8'd6;
        cyc(1);
        chk("coll_count", 32'(ifa.count), 32'd6);
        chk("coll_tick", 32'(ifa.tick), 32'd0);
        chk("coll_limit", 32'(ifa.limit_hit), 32'd0);
        ifa.load = 1'b0;
        cyc(2);
        chk("coll_gap_tick", 32'(ifa.tick), 32'd0);
        cyc(1);
        chk("coll_next_tick", 32'(ifa.tick), 32'd1);
        chk("coll_next_count", 32'(ifa.count), 32'd8);

        // Mid-run asynchronous reset
        cyc(1);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_count", 32'(ifa.count), 32'd0);
        chk("midrst_leds", 32'(ifa.leds), 32'd0);
        chk("midrst_tick", 32'(ifa.tick), 32'd0);
        #1 Reset = 1'b0;
        cyc(2);
        chk("postrst_gap_tick", 32'(ifa.tick), 32'd0);
        cyc(1);
        chk("postrst_tick", 32'(ifa.tick), 32'd1);
        chk("postrst_count", 32'(ifa.count), 32'd2);

        // Freeze for 10 cycles
        ifa.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk($sformatf("freeze_tick%0d", i), 32'(ifa.tick), 32'd0);
        end
        chk("freeze_count", 32'(ifa.count), 32'd2);
        ifa.enable = 1'b1;
        cyc(2);
        chk("thaw_gap_tick", 32'(ifa.tick), 32'd0);
        cyc(1);
        chk("thaw_tick", 32'(ifa.tick), 32'd1);
        chk("thaw_count", 32'(ifa.count), 32'd4);
        ifa.enable = 1'b0;

        // 16-bit, PRESCALE=1: tick every cycle, full-range wrap
        ifb.load = 1'b1; ifb.load_value = 16'hFFFE; ifb.step = 16'd1;
        ifb.dir = 1'b0; ifb.mode = 2'b00; ifb.enable = 1'b1;
        cyc(1);
        chk("b_load_count", 32'(ifb.count), 32'hFFFE);
        chk("b_load_tick", 32'(ifb.tick), 32'd0);
        ifb.load = 1'b0;
        cyc(1);
        chk("b_max_count", 32'(ifb.count), 32'hFFFF);
        chk("b_max_limit", 32'(ifb.limit_hit), 32'd0);
        chk("b_max_leds", 32'(ifb.leds), 32'hF);
        cyc(1);
        chk("b_wrap_count", 32'(ifb.count), 32'd0);
        chk("b_wrap_limit", 32'(ifb.limit_hit), 32'd1);
        chk("b_wrap_tick", 32'(ifb.tick), 32'd1);
        chk("b_wrap_leds", 32'(ifb.leds), 32'd0);
        cyc(1);
        chk("b_cont_tick", 32'(ifb.tick), 32'd1);
        chk("b_cont_count", 32'(ifb.count), 32'd1);
        chk("b_cont_limit", 32'(ifb.limit_hit), 32'd0);
        ifb.dir = 1'b1; ifb.step = 16'd2;
        cyc(1);
        chk("b_down_wrap_count", 32'(ifb.count), 32'hFFFF);
        chk("b_down_wrap_limit", 32'(ifb.limit_hit), 32'd1);
        ifb.mode = 2'b01; ifb.dir = 1'b0; ifb.step = 16'd1;
        cyc(1);
        chk("b_sat_count", 32'(ifb.count), 32'hFFFF);
        chk("b_sat_limit", 32'(ifb.limit_hit), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/tick_counter.md
Name: tick_counter

Overview:
- Parametrised, prescaled step counter that drives the dock LEDs from the count's upper bits.
- Generates its own clock-enable tick from Clock, so no separate slow-clock domain is needed.
- Adds load, up/down, programmable step and three limit modes: wrap, saturate and bounce.
- Sits between the button layer (load/enable/dir) and the LED layer; it is the next-generation LED demo counter.

Parameters:
- WIDTH, 16, count width in bits.
- PRESCALE, 12000000, Clock cycles per count tick; must be >= 1.
- MAX_COUNT, 2**WIDTH-1, inclusive upper count limit; must be >= 1 and <= 2**WIDTH-1.
- LED_COUNT, 4, number of LED outputs; must be <= WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = prescaler and counter run; 0 = frozen.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load.
- step  input  WIDTH  increment/decrement amount per tick.
- dir  input  1  0 = up, 1 = down; ignored in bounce mode.
- mode  input  2  00 = wrap, 01 = saturate, 10 = bounce, 11 = reserved (behaves as wrap).
- count  output  WIDTH  current count; bit 0 is the LSB.
- tick  output  1  one-cycle pulse, high in the cycle the new count is visible.
- limit_hit  output  1  one-cycle pulse alongside tick when a wrap, clamp or reversal occurred.
- leds  output  LED_COUNT  equals count[WIDTH-1 -: LED_COUNT]; driven directly from the count register.

Behaviour:
- Reset (async, Reset=1): count=0, prescaler=0, tick=0, limit_hit=0, internal bounce direction = up.
- Reset takes effect immediately mid-operation; the first tick after release comes PRESCALE enabled cycles later.
- Priority per edge: load > enable/tick > hold.
- Load:
  - count <= min(load_value, MAX_COUNT); prescaler <= 0; tick=0; limit_hit=0.
  - Bounce direction is unchanged.
  - A load in the same cycle as a prescaler terminal count wins; no step is applied.
- Prescaler:
  - While enable=1, counts 0..PRESCALE-1.
  - At PRESCALE-1 it returns to 0 and a step is applied on that edge; tick=1 for exactly the following cycle.
  - PRESCALE=1 gives a step every enabled cycle, with tick held high continuously.
- enable=0: prescaler and count hold; tick=0 and limit_hit=0 the next cycle.
- Step clamping: the effective step is min(step, MAX_COUNT). step=0 still produces tick, count is unchanged and limit_hit=0.
- Arithmetic is done in WIDTH+1 bits; no intermediate overflow is permitted.
- Wrap mode:
  - Up: if count+s > MAX_COUNT, count <= count+s-(MAX_COUNT+1) and limit_hit=1.
  - Down: if s > count, count <= count+(MAX_COUNT+1)-s and limit_hit=1.
  - Otherwise plain add/subtract.
- Saturate mode:
  - Up: if count+s >= MAX_COUNT, count <= MAX_COUNT. limit_hit=1 only if the clamp changed the result or count was already MAX_COUNT with s>0.
  - Down: mirror at 0.
- Bounce mode:
  - Internal direction is used and dir is ignored.
  - Up: if count+s >= MAX_COUNT, count <= MAX_COUNT, direction <= down, limit_hit=1.
  - Down: if count <= s, count <= 0, direction <= up, limit_hit=1.
  - With s=0 there is no reversal.
- Mode, dir and step are sampled only on tick edges; changes between ticks take effect at the next tick. Entering bounce mode keeps the stored internal direction.
- Latency: a step is applied 1 edge after the terminal prescaler cycle; tick, limit_hit and count change together.

Decomposition:
- Shared package: mode encodings MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_BOUNCE=2'b10; the DIR_UP/DIR_DOWN constants.
- Sub-module prescaler: parameter PRESCALE; ports Clock, Reset, enable, clear, terminal. It replaces the old slow-clock divider with a clock-enable generator.
- The step/limit datapath stays in tick_counter.

Test Plan:
- Bench parameters are WIDTH=8, PRESCALE=3, MAX_COUNT=9, LED_COUNT=4 unless noted.
- Reset, wrap up: after reset with enable=1, step=4, dir=0, mode=00 -> count 0,4,8,2 at every 3rd cycle; limit_hit only on the 8->2 tick; tick period 3 cycles.
- Saturate down: load 5, step=3, dir=1, mode=01 -> count 2,0,0; limit_hit on both 2->0 and 0->0 ticks; clamped load of 200 gives count=9.
- Bounce: load 7, step=2, mode=10, dir toggled randomly -> count 9,7,5,3,1,0,2; limit_hit at 9 and 0 only.
- Load vs tick collision: assert load=1 with load_value=6 on the prescaler terminal cycle -> count=6, tick=0, next tick 3 cycles later.
- Mid-run reset and freeze: pulse Reset between edges -> count=0 and leds=0 immediately. With enable=0 for 10 cycles -> no tick, count frozen.
- PRESCALE=1, WIDTH=16, MAX_COUNT=65535, step=1: 65535 -> 0 with limit_hit=1; leds equal count[15:12].
